// File: rtl/calc_pkg.sv
// calc_pkg: definitions shared by the calculator front end and control unit.
//   - opcode constants carried on op (ADD/SUB/AND/XOR)
//   - go-sequencer state encoding, plus a decode helper for the busy flag
package calc_pkg;

  localparam logic [1:0] OP_ADD = 2'b11;
  localparam logic [1:0] OP_SUB = 2'b10;
  localparam logic [1:0] OP_AND = 2'b01;
  localparam logic [1:0] OP_XOR = 2'b00;

  // Three bits wide so the unused encodings exist and can be steered
  // back to IDLE explicitly.
  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_PULSE    = 3'd1,
    ST_BUSY     = 3'd2,
    ST_WAIT_REL = 3'd3
  } seq_state_e;

  function automatic logic is_busy_state(seq_state_e s);
    return (s == ST_PULSE) || (s == ST_BUSY) || (s == ST_WAIT_REL);
  endfunction

endpackage

// File: rtl/calc_go_sequencer_if.sv
// calc_go_sequencer_if: request/completion link between the go sequencer
// (master) and the calculator control unit (slave).
//   go   : master -> slave, one-cycle request strobe
//   op   : master -> slave, opcode, valid whenever go=1, held while busy=1
//   busy : master -> slave, high from go until the button is released
//   done : slave -> master, completion strobe
// Handshake: go acts as valid with no ready; the master never raises a new
// go while busy=1, so the slave needs no backpressure. done acts as the
// completion acknowledge and is only honoured while the master is in BUSY.
interface calc_go_sequencer_if;
  logic       go;
  logic [1:0] op;
  logic       busy;
  logic       done;

  modport master (output go, output op, output busy, input done);
  modport slave  (input go, input op, input busy, output done);
endinterface

// File: rtl/calc_debounce.sv
// calc_debounce: 2-flop synchroniser and debouncer for the GO button.
// Ports:
//   clk, rst     : clock, asynchronous active-low reset
//   btn_raw      : raw asynchronous bouncing button
//   stable       : debounced button level
//   press        : one-cycle pulse on a 0->1 transition of stable
module calc_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_raw,
  output logic stable,
  output logic press
);

  logic             sync1_q, sync1_d;
  logic             sync2_q, sync2_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             stable_q, stable_d;
  logic             stable_prev_q, stable_prev_d;
  logic [1:0]       vld_q, vld_d;
  logic             armed_q, armed_d;

  always_comb begin
    sync1_d       = btn_raw;
    sync2_d       = sync1_q;
    cnt_d         = cnt_q;
    stable_d      = stable_q;
    stable_prev_d = stable_q;
    vld_d         = {vld_q[0], 1'b1};
    armed_d       = armed_q;

    // The counter measures how long the synchronised level has disagreed
    // with stable; any agreement (i.e. a bounce back) restarts it.
    if (sync2_q == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
      stable_d = sync2_q;
      cnt_d    = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end

    // A button held through reset must not fire: presses are only
    // reported once a released level has been seen through the
    // synchroniser (vld_q[1] marks sync2_q as carrying real samples).
    if (vld_q[1] && !sync2_q) begin
      armed_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      cnt_q         <= '0;
      stable_q      <= 1'b0;
      stable_prev_q <= 1'b0;
      vld_q         <= 2'b00;
      armed_q       <= 1'b0;
    end else begin
      sync1_q       <= sync1_d;
      sync2_q       <= sync2_d;
      cnt_q         <= cnt_d;
      stable_q      <= stable_d;
      stable_prev_q <= stable_prev_d;
      vld_q         <= vld_d;
      armed_q       <= armed_d;
    end
  end

  assign stable = stable_q;
  assign press  = stable_q & ~stable_prev_q & armed_q;

endmodule

// File: rtl/calc_go_sequencer.sv
// calc_go_sequencer: converts the raw GO button and op switches into a
// clean one-cycle go pulse plus a held opcode for the control unit.
// Ports:
//   clk, rst    : clock, asynchronous active-low reset (0 = reset)
//   btn_go      : raw GO button
//   sw_op       : raw operation switches
//   bus         : master side of calc_go_sequencer_if (go/op/busy out, done in)
//   overrun     : sticky, a press arrived while not IDLE and was dropped
//   fault       : sticky, done did not arrive within TIMEOUT cycles of BUSY
//   dbg_state   : current sequencer state
//   dbg_stable  : debounced button level
module calc_go_sequencer
  import calc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 16,
  parameter int TIMEOUT         = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 btn_go,
  input  logic [1:0]           sw_op,
  calc_go_sequencer_if.master  bus,
  output logic                 overrun,
  output logic                 fault,
  output seq_state_e           dbg_state,
  output logic                 dbg_stable
);

  localparam int TO_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  logic stable;
  logic press;

  calc_debounce #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .CNT_W           (CNT_W)
  ) u_debounce (
    .clk     (clk),
    .rst     (rst),
    .btn_raw (btn_go),
    .stable  (stable),
    .press   (press)
  );

  logic [1:0]  sw_sync1_q, sw_sync1_d;
  logic [1:0]  sw_sync2_q, sw_sync2_d;
  seq_state_e  state_q, state_d;
  logic [1:0]  op_q, op_d;
  logic [TO_W-1:0] tcnt_q, tcnt_d;
  logic        overrun_q, overrun_d;
  logic        fault_q, fault_d;

  always_comb begin
    sw_sync1_d = sw_op;
    sw_sync2_d = sw_sync1_q;
    state_d    = state_q;
    op_d       = op_q;
    tcnt_d     = tcnt_q;
    overrun_d  = overrun_q;
    fault_d    = fault_q;

    case (state_q)
      ST_IDLE: begin
        if (press) begin
          op_d      = sw_sync2_q;
          overrun_d = 1'b0;
          fault_d   = 1'b0;
          state_d   = ST_PULSE;
        end
      end
      ST_PULSE: begin
        tcnt_d  = '0;
        state_d = ST_BUSY;
      end
      ST_BUSY: begin
        // done takes priority so a reply on the last allowed cycle is
        // not reported as a hang.
        if (bus.done) begin
          state_d = ST_WAIT_REL;
        end else if (tcnt_q == TO_W'(TIMEOUT - 1)) begin
          fault_d = 1'b1;
          state_d = ST_WAIT_REL;
        end else begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      ST_WAIT_REL: begin
        if (!stable) begin
          state_d = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (press && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sw_sync1_q <= 2'b00;
      sw_sync2_q <= 2'b00;
      state_q    <= ST_IDLE;
      op_q       <= OP_XOR;
      tcnt_q     <= '0;
      overrun_q  <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      sw_sync1_q <= sw_sync1_d;
      sw_sync2_q <= sw_sync2_d;
      state_q    <= state_d;
      op_q       <= op_d;
      tcnt_q     <= tcnt_d;
      overrun_q  <= overrun_d;
      fault_q    <= fault_d;
    end
  end

  assign bus.go     = (state_q == ST_PULSE);
  assign bus.op     = op_q;
  assign bus.busy   = is_busy_state(state_q);
  assign overrun    = overrun_q;
  assign fault      = fault_q;
  assign dbg_state  = state_q;
  assign dbg_stable = stable;

endmodule

// File: tb/tb_calc_go_sequencer.sv
module tb_calc_go_sequencer;
  import calc_pkg::*;

  localparam int DB = 4;
  localparam int TO = 16;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst;
  logic       btn_go;
  logic [1:0] sw_op;
  logic       overrun;
  logic       fault;
  seq_state_e dbg_state;
  logic       dbg_stable;

  calc_go_sequencer_if bus ();

  always #5 clk = ~clk;

  calc_go_sequencer #(
    .DEBOUNCE_CYCLES (DB),
    .CNT_W           (4),
    .TIMEOUT         (TO)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .btn_go     (btn_go),
    .sw_op      (sw_op),
    .bus        (bus),
    .overrun    (overrun),
    .fault      (fault),
    .dbg_state  (dbg_state),
    .dbg_stable (dbg_stable)
  );

  // ---------------- scoreboard ----------------
  int         n_cmp = 0;
  int         n_err = 0;
  logic [1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  logic       prev_go   = 1'b0;
  logic       prev_busy = 1'b0;
  logic [1:0] prev_op   = 2'b00;

  // Every go must match a pending press; op may never move while busy.
  always @(negedge clk) begin
    if (bus.go === 1'b1) begin
      check("go_one_cycle", prev_go, 0);
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_go: op=%0d with no press pending (t=%0t)", bus.op, $time);
      end else begin
        check("go_op", bus.op, exp_q.pop_front());
      end
    end
    if (bus.busy === 1'b1 && prev_busy && rst === 1'b1)
      check("op_hold", bus.op, prev_op);
    prev_go   = bus.go;
    prev_busy = bus.busy;
    prev_op   = bus.op;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Raise the button, expect go DB+3 cycles later; returns at the go cycle.
  task automatic press(input logic [1:0] sw);
    int lat;
    lat    = 0;
    sw_op  = sw;
    btn_go = 1'b1;
    exp_q.push_back(sw);
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (bus.go === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("go_latency", lat, DB + 3);
  endtask

  task automatic release_btn();
    btn_go = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (dbg_state == ST_IDLE) break;
    end
    check("release_idle", dbg_state, ST_IDLE);
    check("release_busy", bus.busy, 0);
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic [1:0] sw;
    int         done_at;    // BUSY cycle in which done is seen, 0 = never
    logic       exp_fault;
  } vec_t;

  vec_t vecs[5];

  initial begin
    vecs[0] = '{OP_SUB, 5,  1'b0};
    vecs[1] = '{OP_ADD, 0,  1'b1};
    vecs[2] = '{OP_AND, 16, 1'b0};
    vecs[3] = '{OP_XOR, 1,  1'b0};
    vecs[4] = '{OP_ADD, 15, 1'b0};

    // ---- reset with button held ----
    rst      = 1'b0;
    btn_go   = 1'b1;
    sw_op    = OP_ADD;
    bus.done = 1'b0;
    tick(3);
    check("rst_go", bus.go, 0);
    check("rst_op", bus.op, OP_XOR);
    check("rst_busy", bus.busy, 0);
    check("rst_overrun", overrun, 0);
    check("rst_fault", fault, 0);
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_stable", dbg_stable, 0);
    rst = 1'b1;
    tick(15);
    check("held_no_go_state", dbg_state, ST_IDLE);
    check("held_stable", dbg_stable, 1);
    btn_go = 1'b0;
    tick(10);

    // ---- done outside BUSY ----
    bus.done = 1'b1;
    tick(2);
    bus.done = 1'b0;
    check("done_idle_ignored", dbg_state, ST_IDLE);

    // ---- table: press, done timing / timeout ----
    for (int i = 0; i < 5; i++) begin
      int end_k;
      press(vecs[i].sw);
      check("go_fault_cleared", fault, 0);
      check("go_busy", bus.busy, 1);
      end_k = (vecs[i].done_at == 0) ? TO + 1 : vecs[i].done_at + 1;
      for (int k = 1; k <= end_k; k++) begin
        @(negedge clk);
        check("txn_state", dbg_state, (k < end_k) ? ST_BUSY : ST_WAIT_REL);
        check("txn_fault", fault, (k == end_k) ? vecs[i].exp_fault : 1'b0);
        bus.done = (k == vecs[i].done_at);
      end
      bus.done = 1'b0;
      tick(3);
      check("hold_wait_rel", dbg_state, ST_WAIT_REL);
      check("hold_busy", bus.busy, 1);
      release_btn();
      tick(2);
    end

    // ---- bounce ----
    btn_go = 1'b1; tick(1);
    btn_go = 1'b0; tick(1);
    btn_go = 1'b1; tick(1);
    btn_go = 1'b0;
    for (int k = 0; k < 10; k++) begin
      tick(1);
      check("bounce_stable", dbg_stable, 0);
      check("bounce_state", dbg_state, ST_IDLE);
    end

    // ---- overrun ----
    press(OP_SUB);
    btn_go = 1'b0;
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 6) begin
        btn_go = 1'b1;
        sw_op  = OP_AND;
      end
    end
    check("ovr_flag", overrun, 1);
    check("ovr_state", dbg_state, ST_BUSY);
    check("ovr_op", bus.op, OP_SUB);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    check("ovr_wait_rel", dbg_state, ST_WAIT_REL);
    check("ovr_fault", fault, 0);
    release_btn();
    tick(2);
    press(OP_AND);
    check("ovr_cleared", overrun, 0);
    bus.done = 1'b1;         // seen during PULSE: must be ignored
    tick(1);
    check("done_pulse_ignored", dbg_state, ST_BUSY);
    tick(1);
    bus.done = 1'b0;
    check("done_busy_taken", dbg_state, ST_WAIT_REL);
    release_btn();
    tick(2);

    // ---- mid-operation reset ----
    press(OP_ADD);
    tick(3);
    check("pre_rst_state", dbg_state, ST_BUSY);
    rst = 1'b0;
    #1;
    check("midrst_busy", bus.busy, 0);
    check("midrst_go", bus.go, 0);
    check("midrst_op", bus.op, OP_XOR);
    check("midrst_state", dbg_state, ST_IDLE);
    @(negedge clk);
    rst = 1'b1;
    tick(15);
    check("post_rst_state", dbg_state, ST_IDLE);
    btn_go = 1'b0;
    tick(10);
    press(OP_XOR);
    tick(1);
    bus.done = 1'b1;
    tick(1);
    bus.done = 1'b0;
    release_btn();

    tick(3);
    check("queue_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
